// File: rtl/afp3_actag_pkg.sv
// Shared constants and FSM encoding for the multi-channel assign-acTag sequencer.
// Optional acTag cache is enabled by defining AFP3_ACTAG_CACHE_EN.
package afp3_actag_pkg;

  localparam logic [7:0] ACTAG_OPCODE = 8'h50;
  localparam logic [4:0] AFUTAG_ENC   = 5'b00000;
  localparam logic [2:0] AFUTAG_TYPE  = 3'b001;

  typedef enum logic [1:0] {
    IDLE   = 2'b01,
    WT4GNT = 2'b10
  } state_t;

  function automatic logic [15:0] afutag_f(
    input logic [5:0] ch
  );
    return {2'b00, AFUTAG_TYPE, ch, AFUTAG_ENC};
  endfunction

endpackage

// File: rtl/afp3_eng_fsm_actag_multi_if.sv
// Arbiter request/grant plus the assign-acTag command bus.
// Master drives the command; slave is the arbiter/command consumer.
interface afp3_eng_fsm_actag_multi_if;

  logic        actag_req;
  logic        arb_eng_misc_gnt;
  logic        actag_valid;
  logic [7:0]  actag_opcode;
  logic [11:0] actag_actag;
  logic [15:0] actag_afutag;
  logic [15:0] actag_bdf;

  modport master (
    output actag_req,
    output actag_valid,
    output actag_opcode,
    output actag_actag,
    output actag_afutag,
    output actag_bdf,
    input  arb_eng_misc_gnt
  );

  modport slave (
    input  actag_req,
    input  actag_valid,
    input  actag_opcode,
    input  actag_actag,
    input  actag_afutag,
    input  actag_bdf,
    output arb_eng_misc_gnt
  );

endinterface

// File: rtl/afp3_rr_arb_n.sv
// Round-robin picker: first set request at or after ptr, circularly.
// Grant is one-hot (all zero when no request).
module afp3_rr_arb_n #(
  parameter int N  = 4,
  parameter int IW = 6
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] &&
            j == (int'(ptr) + i) % N) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/afp3_eng_fsm_actag_multi.sv
// Shared assign-acTag sequencer for NUM_CH engine channels.
// Define AFP3_ACTAG_CACHE_EN to skip commands whose acTag is already assigned.
module afp3_eng_fsm_actag_multi
  import afp3_actag_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CH_IDX_W = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [11:0]          cfg_afu_actag_base,
  input  logic                 mmio_eng_use_pasid_for_actag,
  input  logic [NUM_CH*10-1:0] cmd_pasid,
  input  logic [15:0]          cfg_afu_bdf,
  input  logic [NUM_CH-1:0]    start_actag,
  output logic [NUM_CH-1:0]    actag_done,
  output logic                 actag_seq_error,
  output logic [NUM_CH*12-1:0] eng_actag,
  afp3_eng_fsm_actag_multi_if.master cmd
);

  state_t state_q, state_d;
  logic [11:0] base_q;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] set_v, clr_v;
  logic [NUM_CH-1:0] arb_gnt, grant_done;
  logic [CH_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH_IDX_W-1:0] sel_q, sel_d, win_idx;
  logic [11:0] sel_actag;
  logic [5:0] sel6;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      eng_actag[c*12 +: 12] = mmio_eng_use_pasid_for_actag
        ? base_q + {2'b00, cmd_pasid[c*10 +: 10]}
        : base_q + 12'(c);
    end
  end

  afp3_rr_arb_n #(
    .N  (NUM_CH),
    .IW (CH_IDX_W)
  ) u_arb (
    .req (pending_q),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    win_idx   = '0;
    sel_actag = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (arb_gnt[c]) win_idx = CH_IDX_W'(c);
      if (int'(sel_q) == c) sel_actag = eng_actag[c*12 +: 12];
    end
  end

  assign sel6 = 6'(sel_q);

  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    rr_ptr_d         = rr_ptr_q;
    clr_v            = '0;
    grant_done       = '0;
    actag_seq_error  = 1'b0;
    cmd.actag_req    = 1'b0;
    cmd.actag_valid  = 1'b0;
    cmd.actag_opcode = '0;
    cmd.actag_actag  = '0;
    cmd.actag_afutag = '0;
    cmd.actag_bdf    = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          sel_d   = win_idx;
          state_d = WT4GNT;
        end
      end
      WT4GNT: begin
        cmd.actag_req = 1'b1;
        if (cmd.arb_eng_misc_gnt) begin
          cmd.actag_valid  = 1'b1;
          cmd.actag_opcode = ACTAG_OPCODE;
          cmd.actag_actag  = sel_actag;
          cmd.actag_afutag = afutag_f(sel6);
          cmd.actag_bdf    = cfg_afu_bdf;
          for (int c = 0; c < NUM_CH; c++) begin
            if (int'(sel_q) == c) begin
              grant_done[c] = 1'b1;
              clr_v[c]      = 1'b1;
            end
          end
          rr_ptr_d = (int'(sel_q) == NUM_CH - 1)
            ? '0 : sel_q + CH_IDX_W'(1);
          state_d  = IDLE;
        end
      end
      default: begin
        actag_seq_error = 1'b1;
        state_d         = IDLE;
      end
    endcase
  end

`ifdef AFP3_ACTAG_CACHE_EN
  logic [NUM_CH-1:0] assigned_q, hit_v, hit_done_q;
  logic [11:0] cache_q [NUM_CH];
  logic mode_q;
  logic cfg_chg;

  assign cfg_chg =
    (cfg_afu_actag_base != base_q) ||
    (mmio_eng_use_pasid_for_actag != mode_q);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      hit_v[c] = assigned_q[c] &&
        (cache_q[c] == eng_actag[c*12 +: 12]);
    end
  end

  // a config change invalidates every cached acTag, even one granted now
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      assigned_q <= '0;
      hit_done_q <= '0;
      mode_q     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) cache_q[c] <= '0;
    end else begin
      mode_q     <= mmio_eng_use_pasid_for_actag;
      hit_done_q <= start_actag & hit_v;
      for (int c = 0; c < NUM_CH; c++) begin
        if (grant_done[c]) cache_q[c] <= eng_actag[c*12 +: 12];
      end
      if (cfg_chg) assigned_q <= '0;
      else assigned_q <= assigned_q | grant_done;
    end
  end

  assign set_v      = start_actag & ~hit_v;
  assign actag_done = grant_done | hit_done_q;
`else
  assign set_v      = start_actag;
  assign actag_done = grant_done;
`endif

  // set wins over the grant-cycle clear
  assign pending_d = (pending_q & ~clr_v) | set_v;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      base_q    <= cfg_afu_actag_base;
    end
  end

endmodule
